// File: rtl/vrf_pkg.sv
// Shared types and default sizing for the vector register file and its clear sequencer.
package vrf_pkg;

  localparam int VRF_LANES     = 4;
  localparam int VRF_ELEM_W    = 8;
  localparam int VRF_REG_COUNT = 8;

  typedef logic [VRF_ELEM_W-1:0] vrf_elem_t;

  typedef enum logic [1:0] {
    VRF_IDLE,
    VRF_CLEAR,
    VRF_DONE
  } vrf_clr_state_t;

endpackage

// File: rtl/vrf_clear_seq.sv
// Clear sequencer: sweeps one register index per cycle after clrReq, then pulses clrDone.
// Busy for REG_COUNT+1 cycles; clrReq is ignored unless idle.
module vrf_clear_seq
  import vrf_pkg::*;
#(
  parameter int REG_COUNT = VRF_REG_COUNT,
  parameter int SEL_W     = $clog2(REG_COUNT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clrReq,
  output logic             clrBusy,
  output logic             clrDone,
  output logic [SEL_W-1:0] clrIdx,
  output logic             clrStrobe
);

  vrf_clr_state_t   r_state;
  vrf_clr_state_t   w_next_state;
  logic [SEL_W-1:0] r_idx;
  logic             w_last;

  assign w_last = (r_idx == SEL_W'(REG_COUNT - 1));
  assign clrIdx = r_idx;

  // Index wraps back to 0 on the final sweep step because REG_COUNT is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= VRF_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == VRF_CLEAR) begin
        r_idx <= r_idx + SEL_W'(1);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    clrBusy      = 1'b0;
    clrDone      = 1'b0;
    clrStrobe    = 1'b0;
    case (r_state)
      VRF_IDLE: begin
        if (clrReq) w_next_state = VRF_CLEAR;
      end
      VRF_CLEAR: begin
        clrBusy   = 1'b1;
        clrStrobe = 1'b1;
        if (w_last) w_next_state = VRF_DONE;
      end
      VRF_DONE: begin
        clrBusy      = 1'b1;
        clrDone      = 1'b1;
        w_next_state = VRF_IDLE;
      end
      default: w_next_state = VRF_IDLE;
    endcase
  end

endmodule

// File: rtl/vector_register_file.sv
// Vector register file: 2 combinational read ports, 1 lane-masked write port, clear sequencer.
// Optional same-cycle write-to-read forwarding when VRF_BYPASS_EN is defined.
module vector_register_file
  import vrf_pkg::*;
#(
  parameter int REG_COUNT = VRF_REG_COUNT,
  parameter int LANES     = VRF_LANES,
  parameter int ELEM_W    = VRF_ELEM_W,
  parameter int SEL_W     = $clog2(REG_COUNT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    regWrEn,
  input  logic [SEL_W-1:0]        regToWrite,
  input  logic [LANES-1:0]        laneMask,
  input  logic [LANES*ELEM_W-1:0] dataIn,
  input  logic [SEL_W-1:0]        rSel1,
  input  logic [SEL_W-1:0]        rSel2,
  output logic [LANES*ELEM_W-1:0] reg1Out,
  output logic [LANES*ELEM_W-1:0] reg2Out,
  output logic                    wrReady,
  input  logic                    clrReq,
  output logic                    clrBusy,
  output logic                    clrDone
);

  localparam int DATA_W = LANES * ELEM_W;

  logic [DATA_W-1:0] r_mem [REG_COUNT];
  logic              w_clr_busy;
  logic              w_clr_done;
  logic              w_clr_strobe;
  logic [SEL_W-1:0]  w_clr_idx;
  logic              w_wr_accept;

  vrf_clear_seq #(
    .REG_COUNT (REG_COUNT),
    .SEL_W     (SEL_W)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .clrReq    (clrReq),
    .clrBusy   (w_clr_busy),
    .clrDone   (w_clr_done),
    .clrIdx    (w_clr_idx),
    .clrStrobe (w_clr_strobe)
  );

  assign wrReady     = !w_clr_busy;
  assign clrBusy     = w_clr_busy;
  assign clrDone     = w_clr_done;
  assign w_wr_accept = regWrEn && wrReady;

  // Sweep and writes never coincide: writes are only accepted while the sequencer is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        r_mem[r] <= '0;
      end
    end else if (w_clr_strobe) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_accept) begin
      for (int l = 0; l < LANES; l++) begin
        if (laneMask[l]) begin
          r_mem[regToWrite][l*ELEM_W +: ELEM_W] <= dataIn[l*ELEM_W +: ELEM_W];
        end
      end
    end
  end

`ifdef VRF_BYPASS_EN
  always_comb begin
    reg1Out = r_mem[rSel1];
    reg2Out = r_mem[rSel2];
    for (int l = 0; l < LANES; l++) begin
      if (w_wr_accept && laneMask[l]) begin
        if (rSel1 == regToWrite) reg1Out[l*ELEM_W +: ELEM_W] = dataIn[l*ELEM_W +: ELEM_W];
        if (rSel2 == regToWrite) reg2Out[l*ELEM_W +: ELEM_W] = dataIn[l*ELEM_W +: ELEM_W];
      end
    end
  end
`else
  assign reg1Out = r_mem[rSel1];
  assign reg2Out = r_mem[rSel2];
`endif

endmodule

// File: doc/vector_register_file.md
# vector_register_file

Parametrised vector register file for the ASIP decode stage, successor to the scalar register file: `REG_COUNT` registers of `LANES` × `ELEM_W` bits, with two combinational read ports and one lane-masked synchronous write port. It adds a software-triggered clear sequencer that zeroes one register per cycle, with busy/ready handshaking. It also has optional write-to-read bypass. It sits between instruction decode and the vector execute lanes.

## Interface
- `REG_COUNT`, default 8, number of registers; power of 2, ≥2.
- `LANES`, default 4, elements per register.
- `ELEM_W`, default 8, bits per element.
- `SEL_W`, default `$clog2(REG_COUNT)`, selector width; derived, never overridden.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `regWrEn` in 1: write request.
- `regToWrite` in `SEL_W`: write register index.
- `laneMask` in `LANES`: per-lane write enable; bit i covers lane i.
- `dataIn` in `LANES*ELEM_W`: write data; lane i occupies bits `[i*ELEM_W +: ELEM_W]`.
- `rSel1`, `rSel2` in `SEL_W`: read register indices.
- `reg1Out`, `reg2Out` out `LANES*ELEM_W`: read data.
- `wrReady` out 1: write port accepts this cycle.
- `clrReq` in 1: request to clear all registers.
- `clrBusy` out 1: clear sequence in progress.
- `clrDone` out 1: one-cycle pulse when the clear completes.

## Operation
- Storage: `REG_COUNT` × `LANES` elements. All elements reset to 0 asynchronously.
- Write: on the rising `clk` edge with `regWrEn && wrReady`, each lane i where `laneMask[i]=1` takes the dataIn lane. Unmasked lanes hold their value. A write with `laneMask=0` is a no-op.
- `wrReady = !clrBusy`. Writes presented while not ready are dropped. The writer holds its request until ready.
- Reads: combinational, `regNOut = mem[rSelN]`. Both ports may select the same register.
- Clear FSM states:
  - IDLE: transitions to CLEAR when `clrReq=1`.
  - CLEAR: counter `idx` runs from 0 to `REG_COUNT-1`. Each cycle zeroes `mem[idx]` and increments. At `idx=REG_COUNT-1`, transitions to DONE.
  - DONE: `clrDone=1` for exactly one cycle, then IDLE.
- `clrBusy=1` in CLEAR and DONE.
- `clrReq` is ignored while not IDLE; there is no queuing.
- The counter is `SEL_W` bits and wraps to 0 naturally on exit.
- Reads during CLEAR return live contents: already-cleared registers read 0, the rest hold old data.
- Reset mid-clear: the FSM returns to IDLE with `idx=0`, all registers 0, and no `clrDone` pulse.

## Timing
- Reset values: `reg1Out`/`reg2Out` = 0 (storage cleared), `wrReady=1`, `clrBusy=0`, `clrDone=0`.
- Write-to-read latency: 1 cycle. Data is visible on the read port in the cycle after the accepting edge.
- Clear latency: `clrReq` is sampled at edge T. `clrBusy` rises after T. The last register is zeroed at edge T+`REG_COUNT`. `clrDone` is high during cycle T+`REG_COUNT`+1. `wrReady` returns in the cycle after that, for `REG_COUNT+1` busy cycles in total.
- `clrReq` and `regWrEn` sampled in the same IDLE cycle: the write is accepted at that edge, and the clear starts from the same edge. The written register is zeroed later by the sweep.
- Simultaneous reads and write: without bypass, reads return the pre-write value.

## Configuration
- `VRF_BYPASS_EN` defined: when `regWrEn && wrReady` and `rSelN == regToWrite`, `regNOut` returns `dataIn` lanes where `laneMask=1` and stored lanes elsewhere, in the same cycle, combinationally.
- `VRF_BYPASS_EN` undefined: reads always return stored contents, with 1-cycle write-to-read latency.

## Structure
- Shared package `vrf_pkg`:
  - `typedef enum {VRF_IDLE, VRF_CLEAR, VRF_DONE} vrf_clr_state_t`.
  - Default constants `VRF_LANES`, `VRF_ELEM_W`, `VRF_REG_COUNT`.
  - Element typedef `vrf_elem_t`.
- Sub-module `vrf_clear_seq`: holds the FSM and index counter, and outputs `clrBusy`, `clrDone`, the clear index, and the clear-strobe. Storage and read muxing stay in the top.

## Test plan
- Reset, then read all 8 registers → every read is 0x00000000; `wrReady=1`, `clrBusy=0`.
- Write r3=0xA1B2C3D4 with mask 4'b1111, then r3=0x11223344 with mask 4'b0101 → r3 reads 0xA122C344 on both ports.
- Load r0..r7=0xFFFFFFFF, then pulse `clrReq` → `clrBusy` high for 9 cycles; `clrDone` pulses in cycle 9; r0 reads 0 after the first edge while r7 still reads 0xFFFFFFFF; all registers read 0 at the end.
- During CLEAR, hold a write to r5=0x12345678 → `wrReady=0` and no update; the write lands one cycle after `wrReady` returns.
- Assert reset at clear cycle 4 → all registers 0, FSM IDLE, no `clrDone` pulse.
- With `VRF_BYPASS_EN`: r2=0xDEADBEEF stored, write 0x00000055 with mask 4'b0001, `rSel1=2` in the same cycle → `reg1Out=0xDEADBE55` combinationally. Without the macro → 0xDEADBEEF, then 0xDEADBE55 next cycle.
